alu_arbiter: RTL

- Shares the single 8-bit ALU (add/sub, and-bit, xor, shift) between two requesters: port 0 (main datapath) and port 1 (auxiliary unit, e.g. address/compare logic).
- Arbitrates request valid/ready handshakes and drives the ALU's combinational inputs for the granted request.
- Registers each result into a per-requester response slot that is held until the requester consumes it.
- Sits between the decode/execute control and the ALU instance, which it owns internally.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 23 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types and constants for the ALU and its arbiter front end.
package alu_pkg;

  localparam int unsigned ALU_DW = 8;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_XOR   = 2'b10,
    ALU_SHIFT = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e           op;
    logic              sub;
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: add/sub, and, xor, logical left shift (in2 >= 8 yields zero).
module alu
  import alu_pkg::*;
(
  input  alu_op_e           alu_op,
  input  logic              sub,
  input  logic [ALU_DW-1:0] in1,
  input  logic [ALU_DW-1:0] in2,
  output logic [ALU_DW-1:0] result
);

  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADD:   result = sub ? (in1 + (~in2) + ALU_DW'(1)) : (in1 + in2);
      ALU_AND:   result = in1 & in2;
      ALU_XOR:   result = in1 ^ in2;
      ALU_SHIFT: result = in1 << in2;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way grant logic: round-robin on rr_ptr (mode=0) or fixed priority to port 0 (mode=1).
module rr_arb2 (
  input  logic [1:0] elig,
  input  logic       rr_ptr,
  input  logic       mode,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (mode) begin
      if (elig[0]) begin
        grant = 2'b01;
      end else if (elig[1]) begin
        grant = 2'b10;
      end
    end else if (&elig) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; each result lands in a per-port slot held until consumed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [1:0]    req0_op,
  input  logic          req0_sub,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  output logic          resp0_valid,
  input  logic          resp0_ready,
  output logic [DW-1:0] resp0_data,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [1:0]    req1_op,
  input  logic          req1_sub,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          resp1_valid,
  input  logic          resp1_ready,
  output logic [DW-1:0] resp1_data,

  output logic          busy
);

  if (DW != ALU_DW) begin : gen_dw_check
    $error("alu_arbiter: DW must equal %0d", ALU_DW);
  end

  logic          resp0_valid_q, resp1_valid_q;
  logic [DW-1:0] resp0_data_q, resp1_data_q;
  logic          rr_ptr_q;
  logic [1:0]    elig;
  logic [1:0]    grant;
  alu_req_t      alu_req;
  logic [DW-1:0] alu_result;

  // A port with a held result may still issue if that result is consumed this cycle.
  assign elig[0] = req0_valid && (!resp0_valid_q || resp0_ready);
  assign elig[1] = req1_valid && (!resp1_valid_q || resp1_ready);

  rr_arb2 u_arb (
    .elig   (elig),
    .rr_ptr (rr_ptr_q),
    .mode   (ARB_MODE != 0),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign busy       = |grant;

  always_comb begin
    alu_req = '0;
    if (grant[0]) begin
      alu_req.op  = alu_op_e'(req0_op);
      alu_req.sub = req0_sub && (req0_op == 2'b00);
      alu_req.a   = req0_a;
      alu_req.b   = req0_b;
    end else if (grant[1]) begin
      alu_req.op  = alu_op_e'(req1_op);
      alu_req.sub = req1_sub && (req1_op == 2'b00);
      alu_req.a   = req1_a;
      alu_req.b   = req1_b;
    end
  end

  alu u_alu (
    .alu_op (alu_req.op),
    .sub    (alu_req.sub),
    .in1    (alu_req.a),
    .in2    (alu_req.b),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
      rr_ptr_q      <= 1'b0;
    end else begin
      if (grant[0]) begin
        rr_ptr_q <= 1'b1;
      end else if (grant[1]) begin
        rr_ptr_q <= 1'b0;
      end

      // A new grant wins over a same-cycle consume so the slot stays full.
      if (grant[0]) begin
        resp0_data_q  <= alu_result;
        resp0_valid_q <= 1'b1;
      end else if (resp0_valid_q && resp0_ready) begin
        resp0_valid_q <= 1'b0;
      end

      if (grant[1]) begin
        resp1_data_q  <= alu_result;
        resp1_valid_q <= 1'b1;
      end else if (resp1_valid_q && resp1_ready) begin
        resp1_valid_q <= 1'b0;
      end
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_data  = resp0_data_q;
  assign resp1_data  = resp1_data_q;

endmodule
